// File: rtl/tile_console_ctrl_if.sv
// ---------------------------------------------------------------------------
// tile_console_ctrl_if
//   Bundles the character-stream handshake and the single-port tile RAM bus
//   of tile_console_ctrl.
//
//   in_valid / in_data / in_ready : byte stream, accepted when valid && ready
//   mem_addr / mem_we / mem_wr_data : RAM cell address, write strobe, data
//   mem_rd_data : RAM read data, valid one cycle after mem_addr is presented
//
//   master : the console controller (drives the RAM bus and in_ready)
//   slave  : the character source and the RAM
// ---------------------------------------------------------------------------
interface tile_console_ctrl_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [8:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;

  modport master (
    input  in_valid, in_data, mem_rd_data,
    output in_ready, mem_addr, mem_we, mem_wr_data
  );

  modport slave (
    output in_valid, in_data, mem_rd_data,
    input  in_ready, mem_addr, mem_we, mem_wr_data
  );
endinterface

// File: rtl/tile_console_ctrl.sv
// ---------------------------------------------------------------------------
// tile_console_ctrl
//   Turns a byte character stream into writes to the 32x15 tile index RAM
//   scanned out by the text-mode video generator. Keeps a cursor, handles
//   CR (0x0D), LF (0x0A) and backspace (0x08), scrolls the screen up one row
//   when the cursor runs off the bottom, and clears the screen on request.
//
//   G_clock0  : clock, all logic on the rising edge
//   reset     : asynchronous, active-low
//   clear     : single-cycle clear-screen request
//   bus       : character handshake + RAM port (tile_console_ctrl_if.master)
//   busy      : a scroll/fill/clear sequence is running or a clear is queued
//   cursor_col: current column
//   cursor_row: current row
// ---------------------------------------------------------------------------
module tile_console_ctrl #(
  parameter int         P_cols = 32,
  parameter int         P_rows = 15,
  parameter logic [7:0] P_fill = 8'h20
) (
  input  logic                 G_clock0,
  input  logic                 reset,
  input  logic                 clear,
  tile_console_ctrl_if.master  bus,
  output logic                 busy,
  output logic [4:0]           cursor_col,
  output logic [3:0]           cursor_row
);

  // The cell address is row*P_cols + col in 9 bits; the screen must fit.
  if (P_rows * P_cols > 512 || P_cols > 32 || P_rows > 16) begin : g_geometry_check
    $error("tile_console_ctrl: screen geometry does not fit the cell address / cursor widths");
  end

  localparam logic [8:0] COLS9       = 9'(P_cols);
  localparam logic [8:0] SCROLL_LAST = 9'((P_rows - 1) * P_cols - 1);
  localparam logic [8:0] SCREEN_LAST = 9'(P_rows * P_cols - 1);
  localparam logic [4:0] COL_LAST    = 5'(P_cols - 1);
  localparam logic [3:0] ROW_LAST    = 4'(P_rows - 1);

  // Each state names what the RAM bus is doing in the current cycle.
  typedef enum logic [2:0] {IDLE, SCROLL_RD, SCROLL_WR, FILL, CLEAR} state_t;

  state_t     state;
  logic       clear_pending;
  logic       scroll_pending;  // char written on the last cell; scroll follows
  logic [7:0] wr_data_q;

  function automatic logic [8:0] cell_addr(input logic [3:0] row, input logic [4:0] col);
    return 9'(row) * COLS9 + 9'(col);
  endfunction

  // NOTE: continuous assign keeps in_ready purely combinational with no
  // storage, so no latch can be inferred for it.
  assign bus.in_ready = (state == IDLE) && !clear && !clear_pending && !scroll_pending;

  // The RAM returns read data one cycle after the address, and the scroll
  // writes it back in that very cycle, so the copy path bypasses the data
  // register while a scroll write is on the bus.
  assign bus.mem_wr_data = (state == SCROLL_WR) ? bus.mem_rd_data : wr_data_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge G_clock0 or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      clear_pending  <= 1'b0;
      scroll_pending <= 1'b0;
      wr_data_q      <= 8'h00;
      bus.mem_addr   <= 9'd0;
      bus.mem_we     <= 1'b0;
      busy           <= 1'b0;
      cursor_col     <= 5'd0;
      cursor_row     <= 4'd0;
    end else begin
      // A clear that cannot start now is remembered; repeats collapse.
      if (clear && state != IDLE) clear_pending <= 1'b1;

      case (state)
        IDLE: begin
          bus.mem_we <= 1'b0;
          busy       <= 1'b0;
          if (scroll_pending) begin
            // The character write is done; start the scroll.
            scroll_pending <= 1'b0;
            if (clear) clear_pending <= 1'b1;
            state        <= SCROLL_RD;
            bus.mem_addr <= COLS9;
            busy         <= 1'b1;
          end else if (clear || clear_pending) begin
            clear_pending <= 1'b0;
            state         <= CLEAR;
            bus.mem_addr  <= 9'd0;
            bus.mem_we    <= 1'b1;
            wr_data_q     <= P_fill;
            cursor_col    <= 5'd0;
            cursor_row    <= 4'd0;
            busy          <= 1'b1;
          end else if (bus.in_valid) begin
            case (bus.in_data)
              8'h0D: cursor_col <= 5'd0;
              8'h0A: begin
                cursor_col <= 5'd0;
                if (cursor_row == ROW_LAST) begin
                  state        <= SCROLL_RD;
                  bus.mem_addr <= COLS9;
                  busy         <= 1'b1;
                end else begin
                  cursor_row <= cursor_row + 4'd1;
                end
              end
              8'h08: begin
                if (cursor_col != 5'd0) begin
                  cursor_col   <= cursor_col - 5'd1;
                  bus.mem_addr <= cell_addr(cursor_row, cursor_col - 5'd1);
                  bus.mem_we   <= 1'b1;
                  wr_data_q    <= P_fill;
                end
              end
              default: begin
                bus.mem_addr <= cell_addr(cursor_row, cursor_col);
                bus.mem_we   <= 1'b1;
                wr_data_q    <= bus.in_data;
                if (cursor_col == COL_LAST) begin
                  cursor_col <= 5'd0;
                  if (cursor_row == ROW_LAST) begin
                    scroll_pending <= 1'b1;
                    busy           <= 1'b1;
                  end else begin
                    cursor_row <= cursor_row + 4'd1;
                  end
                end else begin
                  cursor_col <= cursor_col + 5'd1;
                end
              end
            endcase
          end
        end

        // Read the cell one row below the destination.
        SCROLL_RD: begin
          state        <= SCROLL_WR;
          bus.mem_addr <= bus.mem_addr - COLS9;
          bus.mem_we   <= 1'b1;
        end

        // Write the fetched byte to the destination, then step on.
        SCROLL_WR: begin
          if (bus.mem_addr == SCROLL_LAST) begin
            state        <= FILL;
            bus.mem_addr <= bus.mem_addr + 9'd1;
            bus.mem_we   <= 1'b1;
            wr_data_q    <= P_fill;
          end else begin
            state        <= SCROLL_RD;
            bus.mem_addr <= bus.mem_addr + 9'd1 + COLS9;
            bus.mem_we   <= 1'b0;
          end
        end

        // FILL blanks the last row; CLEAR blanks the whole screen.
        FILL, CLEAR: begin
          if (bus.mem_addr == SCREEN_LAST) begin
            state      <= IDLE;
            bus.mem_we <= 1'b0;
            busy       <= clear_pending || clear;
          end else begin
            bus.mem_addr <= bus.mem_addr + 9'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_console_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tile_console_ctrl
//   Directed bench for tile_console_ctrl with a synchronous-read RAM model.
//   The RAM is preset to addr ^ 0x5A while reset is low.
// ---------------------------------------------------------------------------
module tb_tile_console_ctrl;
  logic       G_clock0 = 1'b0;
  logic       reset    = 1'b0;
  logic       clear    = 1'b0;
  logic       busy;
  logic [4:0] cursor_col;
  logic [3:0] cursor_row;

  int checks = 0;
  int errors = 0;

  tile_console_ctrl_if bus ();

  tile_console_ctrl dut (
    .G_clock0   (G_clock0),
    .reset      (reset),
    .clear      (clear),
    .bus        (bus),
    .busy       (busy),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 G_clock0 = ~G_clock0;

  // Tile RAM: read data registered one cycle after the address.
  logic [7:0] ram [512];
  always @(posedge G_clock0 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 512; i++) ram[i] <= 8'(i) ^ 8'h5A;
      bus.mem_rd_data <= 8'h00;
    end else begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wr_data;
      bus.mem_rd_data <= ram[bus.mem_addr];
    end
  end

  // Write counter, sampled at the edge that commits each write.
  int wr_count = 0;
  bit hi_write = 1'b0;
  always @(posedge G_clock0) begin
    if (bus.mem_we === 1'b1) begin
      wr_count++;
      if (bus.mem_addr >= 9'd480) hi_write = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte once in_ready is high; returns at the negedge of the
  // cycle after acceptance, where any resulting write is on the bus.
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 2000) begin
      @(negedge G_clock0);
      n++;
    end
    if (n >= 2000) check("send_ready_timeout", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge G_clock0);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int base, cyc, rdy_bad, seq_bad;
    logic [8:0] a0, a1, a927, a929;
    logic       w0, w1, w927, w928, b928, r928, w929;
    logic [7:0] d1, d929;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // ---- reset state
    repeat (3) @(negedge G_clock0);
    check("rst_we",       32'(bus.mem_we),      0);
    check("rst_addr",     32'(bus.mem_addr),    0);
    check("rst_wr_data",  32'(bus.mem_wr_data), 0);
    check("rst_busy",     32'(busy),            0);
    check("rst_col",      32'(cursor_col),      0);
    check("rst_row",      32'(cursor_row),      0);
    reset = 1'b1;
    @(negedge G_clock0);
    check("rst_in_ready", 32'(bus.in_ready),    1);

    // ---- single printable character
    send(8'h41);
    check("t1_we",      32'(bus.mem_we),      1);
    check("t1_addr",    32'(bus.mem_addr),    0);
    check("t1_data",    32'(bus.mem_wr_data), 'h41);
    check("t1_col",     32'(cursor_col),      1);
    check("t1_busy",    32'(busy),            0);
    @(negedge G_clock0);
    check("t1_we_off",  32'(bus.mem_we),      0);
    check("t1_addr_hold", 32'(bus.mem_addr),  0);

    // ---- CR then 33 characters with a line wrap
    send(8'h0D);
    check("cr_we",  32'(bus.mem_we),  0);
    check("cr_col", 32'(cursor_col),  0);
    base = wr_count;
    for (int i = 0; i < 33; i++) send(8'h30 + 8'(i));
    check("t2_addr", 32'(bus.mem_addr),    32);
    check("t2_data", 32'(bus.mem_wr_data), 'h50);
    check("t2_col",  32'(cursor_col),      1);
    check("t2_row",  32'(cursor_row),      1);
    @(negedge G_clock0);
    check("t2_writes", 32'(wr_count - base), 33);

    // ---- backspace at col 5 and at col 0
    send(8'h61); send(8'h62); send(8'h63); send(8'h64);
    send(8'h08);
    check("bs_we",   32'(bus.mem_we),      1);
    check("bs_addr", 32'(bus.mem_addr),    36);
    check("bs_data", 32'(bus.mem_wr_data), 'h20);
    check("bs_col",  32'(cursor_col),      4);
    send(8'h0D);
    base = wr_count;
    send(8'h08);
    check("bs0_we",  32'(bus.mem_we), 0);
    check("bs0_col", 32'(cursor_col), 0);
    check("bs0_row", 32'(cursor_row), 1);
    @(negedge G_clock0);
    check("bs0_writes", 32'(wr_count - base), 0);

    // ---- walk to the bottom row and scroll
    repeat (13) send(8'h0A);
    check("lf_row", 32'(cursor_row), 14);
    check("lf_col", 32'(cursor_col), 0);
    send(8'h78); send(8'h79); send(8'h7A);
    send(8'h0A);
    base = wr_count; cyc = 0; rdy_bad = 0;
    a0 = '0; w0 = 1'b0; a1 = '0; w1 = 1'b0; d1 = '0;
    while (busy === 1'b1 && cyc < 2000) begin
      if (cyc == 0) begin a0 = bus.mem_addr; w0 = bus.mem_we; end
      if (cyc == 1) begin a1 = bus.mem_addr; w1 = bus.mem_we; d1 = bus.mem_wr_data; end
      if (bus.in_ready !== 1'b0) rdy_bad++;
      cyc++;
      @(negedge G_clock0);
    end
    check("scr_busy_cycles", 32'(cyc),              928);
    check("scr_writes",      32'(wr_count - base),  480);
    check("scr_rd_addr",     32'(a0),               32);
    check("scr_rd_we",       32'(w0),               0);
    check("scr_wr_addr",     32'(a1),               0);
    check("scr_wr_we",       32'(w1),               1);
    check("scr_wr_data",     32'(d1),               'h50);
    check("scr_ready_low",   32'(rdy_bad),          0);
    check("scr_col",         32'(cursor_col),       0);
    check("scr_row",         32'(cursor_row),       14);
    check("scr_ram0",        32'(ram[0]),           'h50);
    check("scr_ram1",        32'(ram[1]),           'h61);
    check("scr_ram4",        32'(ram[4]),           'h20);
    check("scr_ram68",       32'(ram[68]),          'h3E);
    check("scr_ram416",      32'(ram[416]),         'h78);
    check("scr_ram447",      32'(ram[447]),         'h85);
    check("scr_ram448",      32'(ram[448]),         'h20);
    check("scr_ram450",      32'(ram[450]),         'h20);
    check("scr_ram480",      32'(ram[480]),         'hBA);

    // ---- clear from IDLE, colliding with a character
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h42;
    #1;
    check("clr_prio_ready", 32'(bus.in_ready), 0);
    @(negedge G_clock0);
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_col", 32'(cursor_col), 0);
    check("clr_row", 32'(cursor_row), 0);
    base = wr_count; cyc = 0; rdy_bad = 0; seq_bad = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 9'(cyc) || bus.mem_wr_data !== 8'h20) seq_bad++;
      if (bus.in_ready !== 1'b0) rdy_bad++;
      cyc++;
      @(negedge G_clock0);
    end
    check("clr_cycles",    32'(cyc),             480);
    check("clr_sequence",  32'(seq_bad),         0);
    check("clr_ready_low", 32'(rdy_bad),         0);
    check("clr_writes",    32'(wr_count - base), 480);
    check("clr_no_hi",     32'(hi_write),        0);
    check("clr_ram0",      32'(ram[0]),          'h20);
    check("clr_ram479",    32'(ram[479]),        'h20);
    check("clr_ram480",    32'(ram[480]),        'hBA);

    // ---- clear during a scroll, then reset in the middle of the clear
    repeat (14) send(8'h0A);
    check("t6_row", 32'(cursor_row), 14);
    send(8'h0A);
    a927 = '0; w927 = 1'b0; w928 = 1'b1; b928 = 1'b0; r928 = 1'b1;
    a929 = '1; w929 = 1'b0; d929 = '0;
    for (int i = 0; i < 935; i++) begin
      clear = (i == 100 || i == 300);
      if (i == 927) begin a927 = bus.mem_addr; w927 = bus.mem_we; end
      if (i == 928) begin w928 = bus.mem_we; b928 = busy; r928 = bus.in_ready; end
      if (i == 929) begin a929 = bus.mem_addr; w929 = bus.mem_we; d929 = bus.mem_wr_data; end
      @(negedge G_clock0);
    end
    clear = 1'b0;
    check("pend_fill_last_addr", 32'(a927), 479);
    check("pend_fill_last_we",   32'(w927), 1);
    check("pend_idle_we",        32'(w928), 0);
    check("pend_idle_busy",      32'(b928), 1);
    check("pend_idle_ready",     32'(r928), 0);
    check("pend_clr_addr",       32'(a929), 0);
    check("pend_clr_we",         32'(w929), 1);
    check("pend_clr_data",       32'(d929), 'h20);
    check("pend_clr_busy",       32'(busy), 1);
    repeat (50) @(negedge G_clock0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_we",   32'(bus.mem_we),   0);
    check("arst_busy", 32'(busy),         0);
    check("arst_col",  32'(cursor_col),   0);
    check("arst_row",  32'(cursor_row),   0);
    check("arst_addr", 32'(bus.mem_addr), 0);
    base = wr_count;
    repeat (5) @(negedge G_clock0);
    reset = 1'b1;
    repeat (10) @(negedge G_clock0);
    check("arst_no_writes", 32'(wr_count - base), 0);
    check("arst_idle_busy", 32'(busy),            0);
    check("arst_in_ready",  32'(bus.in_ready),    1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
